cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; fixed at 4 for this release.
REQ-002 Parameter CW, default 4: counter width; the terminal count is 2^CW-1 (4'hF).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port mr, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, NREQ: per-requester interval request, level; held high until done or abort.
REQ-006 Port dur, input, NREQ*CW: packed interval lengths; dur[i*CW +: CW] belongs to requester i.
REQ-007 Port gnt, output, NREQ: one-hot grant, high in LOAD, RUN and DONE.
REQ-008 Port done, output, NREQ: one-cycle completion pulse to the granted requester.
REQ-009 Port busy, output, 1: high in LOAD and RUN.
REQ-010 Port q_mon, output, CW: live counter value, for monitoring only.

Function
REQ-011 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-012 IDLE SHALL stay in IDLE while req==0.
- Otherwise it latches the winner into gnt_id and moves to LOAD.
REQ-013 The winner SHALL be the first asserted req at or after ptr, searching cyclically upward (ptr, ptr+1, ... mod NREQ).
REQ-014 LOAD SHALL drive the counter's active-low load with d = 4'hF - dur[gnt_id], sampled in that cycle, then move to RUN.
REQ-015 RUN SHALL assert the counter enable every cycle and move to DONE in the cycle when q==4'hF.
- This gives exactly dur+1 cycles in RUN.
REQ-016 DONE SHALL assert done[gnt_id] for exactly one cycle, set ptr = gnt_id+1 mod NREQ, and return to IDLE.
REQ-017 Latency: for a req first seen in IDLE at cycle 0:
- LOAD at cycle 1;
- RUN at cycles 2..dur+2;
- done at cycle dur+3.
REQ-018 dur==0 SHALL load 4'hF, spend one RUN cycle, and pulse done at cycle 3.
REQ-019 dur==15 SHALL load 4'h0, count through the full range without wrap-around, and spend 16 RUN cycles.
REQ-020 If req[gnt_id] deasserts in LOAD or RUN, the FSM SHALL abort to IDLE on the next edge.
- No done pulse is issued.
- ptr advances to gnt_id+1.
- Counter contents are don't-care until the next LOAD.
REQ-021 Changes to req of non-granted requesters during LOAD, RUN or DONE SHALL NOT affect the current interval.
REQ-022 The counter enable SHALL be low outside RUN, so q_mon holds its value in IDLE and DONE.
REQ-023 gnt, done and busy SHALL be decoded only from the registered state and gnt_id, with no combinational path from req or dur.

Reset
REQ-024 mr low SHALL asynchronously force, at any point including mid-RUN:
- state=IDLE, ptr=0, gnt_id=0;
- counter q=0, co=0;
- gnt=0, done=0, busy=0, q_mon=0.
REQ-025 After mr is released, the first grant SHALL go to the lowest-index asserted req.

Structure
REQ-026 Shared package cnt_sched_pkg SHALL hold:
- the state encoding (2-bit, IDLE=0, LOAD=1, RUN=2, DONE=3);
- NREQ and CW defaults;
- the TERM=4'hF constant.
REQ-027 The counter SHALL be a separate sub-module, interval_cnt4, with the following behaviour:
- 4-bit loadable up-counter.
- Ports: clk, mr, load_n, en, d, q, co.
- Priority order: mr, then load, then en.
- co is high while q==4'hF.
- q wraps from 4'hF to 0.
REQ-028 cnt_sched SHALL contain only the FSM, the round-robin pointer and the output decode; its total RTL SHALL fit in 120-400 lines.

Verification
REQ-029 req=0010, dur[1]=3 -> gnt=0010 during cycles 1-6; busy during cycles 1-5; done=0010 only at cycle 6; q_mon reaches 4'hF at cycle 5.
REQ-030 req=0001, dur[0]=0 -> load 4'hF; done=0001 at cycle 3; busy for 2 cycles.
REQ-031 req=1111 held, all dur=1 -> grants in order 0001, 0010, 0100, 1000, then 0001 again; each done follows its grant by 3 cycles.
REQ-032 req=0100, dur[2]=9; drop req[2] at the 3rd RUN cycle -> IDLE on the next edge, done stays 0, the next grant honours ptr=3.
REQ-033 mr pulsed low mid-RUN -> all outputs 0 immediately (asynchronous); after release, req=1010 -> gnt=0010 first.
REQ-034 dur=15 -> q_mon steps 0..15 with no wrap; done at cycle 18.

Source files
------------

// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the interval scheduler: state encoding, size defaults, terminal count.
package cnt_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int NREQ_DEF = 4;
   localparam int CW_DEF   = 4;
   localparam logic [3:0] TERM = 4'hF;

endpackage

// File: rtl/cnt_sched_if.sv
// Requester-side bus of the scheduler: level requests and lengths in, grant/done/busy/monitor out.
interface cnt_sched_if #(
   parameter int NREQ = cnt_sched_pkg::NREQ_DEF,
   parameter int CW   = cnt_sched_pkg::CW_DEF
);
   logic [NREQ-1:0]    req;
   logic [NREQ*CW-1:0] dur;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;
   logic [CW-1:0]      q_mon;

   modport master (output req, dur, input gnt, done, busy, q_mon);
   modport slave  (input req, dur, output gnt, done, busy, q_mon);
endinterface

// File: rtl/interval_cnt4.sv
// 4-bit loadable up-counter, wraps F->0; carry-out flags the terminal count.
// Single-cycle update; reset beats load, load beats enable.
module interval_cnt4 import cnt_sched_pkg::*; (
   input  logic       clk,
   input  logic       mr,
   input  logic       load_n,
   input  logic       en,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       co
);
   logic [3:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (!load_n)
         q_d = d;
      else if (en)
         q_d = q_q + 4'd1;
   end

   always_ff @(posedge clk or negedge mr) begin
      if (!mr)
         q_q <= 4'd0;
      else
         q_q <= q_d;
   end

   assign q  = q_q;
   assign co = (q_q == TERM);
endmodule

// File: rtl/cnt_sched.sv
// Round-robin interval scheduler: grant at +1 cycle, dur+1 RUN cycles, done pulse at dur+3.
// Requests are levels; dropping the granted request during LOAD/RUN aborts without done.
module cnt_sched import cnt_sched_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic       clk,
   input  logic       mr,
   cnt_sched_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   gnt_id_q, gnt_id_d;
   logic [IW-1:0]   win_id, idx, nxt_id;
   logic            win_vld;
   logic            gnt_req;
   logic [NREQ-1:0] gnt_oh;
   logic [CW-1:0]   cnt_val, cnt_d_in;
   logic            cnt_co, cnt_load_n, cnt_en;

   // First asserted request at or after ptr, wrapping around.
   always_comb begin
      win_vld = 1'b0;
      win_id  = ptr_q;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IW'((int'(ptr_q) + k) % NREQ);
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   assign gnt_req = bus.req[gnt_id_q];
   assign nxt_id  = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + IW'(1);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_id_d = gnt_id_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               gnt_id_d = win_id;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!gnt_req) begin
               ptr_d   = nxt_id;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!gnt_req) begin
               ptr_d   = nxt_id;
               state_d = ST_IDLE;
            end else if (cnt_co) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ptr_d   = nxt_id;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gnt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_id_q <= gnt_id_d;
      end
   end

   // Enable is held off once at terminal count so q_mon never wraps into DONE.
   assign cnt_load_n = (state_q != ST_LOAD);
   assign cnt_en     = (state_q == ST_RUN) && !cnt_co;
   assign cnt_d_in   = CW'(TERM) - bus.dur[int'(gnt_id_q)*CW +: CW];

   interval_cnt4 u_cnt (
      .clk    (clk),
      .mr     (mr),
      .load_n (cnt_load_n),
      .en     (cnt_en),
      .d      (cnt_d_in),
      .q      (cnt_val),
      .co     (cnt_co)
   );

   assign gnt_oh    = NREQ'(1) << gnt_id_q;
   assign bus.gnt   = (state_q != ST_IDLE) ? gnt_oh : '0;
   assign bus.done  = (state_q == ST_DONE) ? gnt_oh : '0;
   assign bus.busy  = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign bus.q_mon = cnt_val;
endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: cycle-by-cycle reference model plus literal spot checks.
module tb_cnt_sched;
   logic clk;
   logic mr;

   cnt_sched_if bus ();

   cnt_sched dut (
      .clk (clk),
      .mr  (mr),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: an interval is described by owner, age since grant and length.
   int m_act, m_own, m_age, m_len, m_ptr, m_q, m_qk;

   logic [3:0] lg_gnt  [32];
   logic [3:0] lg_done [32];
   logic       lg_busy [32];
   logic [3:0] lg_q    [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_own = 0; m_age = 0; m_len = 0; m_ptr = 0; m_q = 0; m_qk = 1;
   endtask

   // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic cyc(input int c);
      logic [3:0] e_gnt, e_done, e_q;
      logic       e_busy;
      int         q_chk, found, k_idx;
      @(negedge clk);
      if (!mr) model_reset();
      e_gnt = 4'h0; e_done = 4'h0; e_busy = 1'b0;
      e_q = 4'(m_q); q_chk = m_qk;
      if (m_act != 0) begin
         e_gnt = 4'(1 << m_own);
         if (m_age == 0) begin
            e_busy = 1'b1;
         end else if (m_age <= m_len + 1) begin
            e_busy = 1'b1;
            e_q    = 4'(15 - m_len + m_age - 1);
            q_chk  = 1;
         end else begin
            e_done = 4'(1 << m_own);
            e_q    = 4'hF;
            q_chk  = 1;
         end
      end
      chk($sformatf("gnt@%0t", $time), 32'(bus.gnt), 32'(e_gnt));
      chk($sformatf("done@%0t", $time), 32'(bus.done), 32'(e_done));
      chk($sformatf("busy@%0t", $time), 32'(bus.busy), 32'(e_busy));
      if (q_chk != 0) chk($sformatf("q_mon@%0t", $time), 32'(bus.q_mon), 32'(e_q));
      lg_gnt[c] = bus.gnt; lg_done[c] = bus.done; lg_busy[c] = bus.busy; lg_q[c] = bus.q_mon;
      if (mr) begin
         m_q = int'(e_q); m_qk = q_chk;
         if (m_act == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               k_idx = (m_ptr + k) % 4;
               if (found == 0 && bus.req[k_idx]) begin
                  found = 1; m_own = k_idx;
               end
            end
            if (found != 0) begin m_act = 1; m_age = 0; end
         end else if (m_age <= m_len + 1) begin
            if (!bus.req[m_own]) begin
               m_act = 0; m_ptr = (m_own + 1) % 4; m_qk = 0;
            end else begin
               if (m_age == 0) m_len = int'(bus.dur[m_own*4 +: 4]);
               m_age++;
            end
         end else begin
            m_act = 0; m_ptr = (m_own + 1) % 4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic scen(input logic [3:0] r, input logic [15:0] d, input int n,
                       input int drop_c, input logic [3:0] drop_m);
      bus.req = r;
      bus.dur = d;
      for (int c = 0; c < n; c++) begin
         cyc(c);
         if (c + 1 == drop_c) bus.req = bus.req & ~drop_m;
      end
      bus.req = 4'h0;
      repeat (3) cyc(31);
   endtask

   task automatic do_reset(input string tag);
      mr = 1'b0;
      #1;
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
      chk({tag, "_done"}, 32'(bus.done), 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_q"}, 32'(bus.q_mon), 32'h0);
      cyc(31);
      mr = 1'b1;
   endtask

   initial begin
      mr = 1'b0;
      bus.req = 4'h0;
      bus.dur = 16'h0;
      model_reset();
      repeat (3) cyc(31);
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_q", 32'(bus.q_mon), 32'h0);
      mr = 1'b1;
      repeat (2) cyc(31);

      // requester 1, dur 3
      scen(4'b0010, 16'h0030, 8, 7, 4'b0010);
      chk("d3_gnt0", 32'(lg_gnt[0]), 32'h0);
      chk("d3_gnt1", 32'(lg_gnt[1]), 32'h2);
      chk("d3_gnt6", 32'(lg_gnt[6]), 32'h2);
      chk("d3_gnt7", 32'(lg_gnt[7]), 32'h0);
      chk("d3_busy5", 32'(lg_busy[5]), 32'h1);
      chk("d3_busy6", 32'(lg_busy[6]), 32'h0);
      chk("d3_done5", 32'(lg_done[5]), 32'h0);
      chk("d3_done6", 32'(lg_done[6]), 32'h2);
      chk("d3_q2", 32'(lg_q[2]), 32'hC);
      chk("d3_q5", 32'(lg_q[5]), 32'hF);
      chk("d3_q6", 32'(lg_q[6]), 32'hF);

      // requester 0, dur 0
      scen(4'b0001, 16'h0000, 5, 4, 4'b0001);
      chk("d0_gnt1", 32'(lg_gnt[1]), 32'h1);
      chk("d0_busy1", 32'(lg_busy[1]), 32'h1);
      chk("d0_busy2", 32'(lg_busy[2]), 32'h1);
      chk("d0_busy3", 32'(lg_busy[3]), 32'h0);
      chk("d0_q2", 32'(lg_q[2]), 32'hF);
      chk("d0_done2", 32'(lg_done[2]), 32'h0);
      chk("d0_done3", 32'(lg_done[3]), 32'h1);

      // requester 0, dur 15: full range, no wrap
      scen(4'b0001, 16'h000F, 20, 19, 4'b0001);
      chk("d15_q2", 32'(lg_q[2]), 32'h0);
      chk("d15_q9", 32'(lg_q[9]), 32'h7);
      chk("d15_q17", 32'(lg_q[17]), 32'hF);
      chk("d15_q18", 32'(lg_q[18]), 32'hF);
      chk("d15_busy17", 32'(lg_busy[17]), 32'h1);
      chk("d15_busy18", 32'(lg_busy[18]), 32'h0);
      chk("d15_done17", 32'(lg_done[17]), 32'h0);
      chk("d15_done18", 32'(lg_done[18]), 32'h1);

      // reset asserted mid-RUN, then lowest index wins
      bus.req = 4'b0001;
      bus.dur = 16'h0008;
      for (int c = 0; c < 5; c++) cyc(c);
      chk("mr_busy_pre", 32'(lg_busy[4]), 32'h1);
      bus.req = 4'b1010;
      do_reset("mr_mid");
      scen(4'b1010, 16'h3333, 3, 0, 4'h0);
      chk("mr_first_gnt", 32'(lg_gnt[1]), 32'h2);

      // all requesting, dur 1: strict rotation
      do_reset("mr_rr");
      scen(4'b1111, 16'h1111, 25, 0, 4'h0);
      chk("rr_g1", 32'(lg_gnt[1]), 32'h1);
      chk("rr_g6", 32'(lg_gnt[6]), 32'h2);
      chk("rr_g11", 32'(lg_gnt[11]), 32'h4);
      chk("rr_g16", 32'(lg_gnt[16]), 32'h8);
      chk("rr_g21", 32'(lg_gnt[21]), 32'h1);
      chk("rr_d4", 32'(lg_done[4]), 32'h1);
      chk("rr_d9", 32'(lg_done[9]), 32'h2);
      chk("rr_d14", 32'(lg_done[14]), 32'h4);
      chk("rr_d19", 32'(lg_done[19]), 32'h8);
      chk("rr_d24", 32'(lg_done[24]), 32'h1);

      // abort: requester 2 drops in its third RUN cycle
      scen(4'b0100, 16'h0900, 8, 4, 4'b0100);
      chk("ab_gnt4", 32'(lg_gnt[4]), 32'h4);
      chk("ab_busy4", 32'(lg_busy[4]), 32'h1);
      chk("ab_gnt5", 32'(lg_gnt[5]), 32'h0);
      chk("ab_busy5", 32'(lg_busy[5]), 32'h0);
      for (int c = 0; c < 8; c++) chk($sformatf("ab_done%0d", c), 32'(lg_done[c]), 32'h0);
      scen(4'b1111, 16'h1111, 3, 0, 4'h0);
      chk("ab_next_gnt", 32'(lg_gnt[1]), 32'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
